axis_broadcaster: RTL and testbench
===================================

AXIS_BROADCASTER -- requirements
Module: axis_broadcaster

Interface
REQ-001 The block SHALL be clocked by one clock and reset by one asynchronous, active-high reset; no other clock or reset exists.
REQ-002 Parameter AXIS_TDATA_WIDTH, default 32, SHALL set the tdata width in bits (multiple of 8, 8..512).
REQ-003 Parameter NUM_MASTERS, default 2, SHALL set the number of master ports (2..8).
REQ-004 axis_aclk  input  1  block clock, all logic on rising edge.
REQ-005 axis_areset  input  1  asynchronous active-high reset.
REQ-006 mode  input  1  0 = broadcast to enable_mask, 1 = route to route_sel.
REQ-007 enable_mask  input  NUM_MASTERS  broadcast target set.
REQ-008 route_sel  input  3  route-mode target index.
REQ-009 s00_axis_tvalid / tready / tlast  in / out / in  1 each  slave handshake.
REQ-010 s00_axis_tdata  input  AXIS_TDATA_WIDTH  and s00_axis_tstrb  input  AXIS_TDATA_WIDTH/8.
REQ-011 m_axis_tvalid / m_axis_tready / m_axis_tlast  out / in / out  NUM_MASTERS  bit i = master i.
REQ-012 m_axis_tdata  output  NUM_MASTERS*AXIS_TDATA_WIDTH  and m_axis_tstrb  output  NUM_MASTERS*AXIS_TDATA_WIDTH/8, master i in slice i.

Function
REQ-013 The block SHALL hold one beat (data, strb, last, target mask T) in a buffer with flag buf_valid.
REQ-014 A slave beat SHALL be accepted when s00_axis_tvalid & s00_axis_tready, loading the buffer; latency from acceptance to m_axis_tvalid is exactly 1 cycle.
REQ-015 m_axis_tvalid[i] SHALL equal buf_valid & T[i] & ~done[i]; all master tdata/tstrb/tlast slices SHALL show the buffered beat.
REQ-016 done[i] SHALL set on m_axis_tvalid[i] & m_axis_tready[i] and clear when the beat completes.
REQ-017 A beat SHALL complete in the cycle where every T[i] bit is done or handshaking; masters may accept in different cycles, each exactly once.
REQ-018 s00_axis_tready SHALL equal ~axis_areset & (~buf_valid | complete), giving one beat per cycle when all targets are ready.
REQ-019 T SHALL be enable_mask in mode 0 and one-hot(route_sel) in mode 1, sampled only on the first beat of a packet and held for all later beats up to and including tlast.
REQ-020 Packet state SHALL be START after reset or after an accepted tlast beat, and MID after an accepted non-tlast beat; mode, enable_mask and route_sel changes mid-packet SHALL have no effect.
REQ-021 If T is zero (empty mask, or route_sel >= NUM_MASTERS), the beat SHALL be consumed and discarded with complete asserted on its first buffered cycle and no m_axis_tvalid.
REQ-022 Simultaneous completion and new slave acceptance SHALL reload the buffer in the same edge with no bubble.
REQ-023 tstrb and tlast SHALL pass through unmodified; no data width conversion occurs.

Reset
REQ-024 While axis_areset is high: buf_valid=0, done=0, packet state START, all m_axis_tvalid=0, s00_axis_tready=0, data/strb/last registers 0.
REQ-025 Reset asserted mid-packet SHALL discard the buffered beat and packet state; s00_axis_tready SHALL be 1 on the first edge after deassertion.

Configuration
REQ-026 Macro AXIS_BCAST_STATS_EN, when defined, SHALL add outputs stat_pkt_count (32) and stat_drop_count (32), both reset to 0.
REQ-027 With it, stat_pkt_count SHALL increment on each completed tlast beat with nonzero T and stat_drop_count on each discarded beat, both wrapping 0xFFFFFFFF -> 0.
REQ-028 Without it, those ports and counters SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-029 NUM_MASTERS=2, mode 0, mask 2'b11, both tready=1, 4-beat packet 0x1..0x4 -> both masters receive 0x1..0x4, tlast on beat 4, one beat per cycle, first m_axis_tvalid 1 cycle after acceptance.
REQ-030 Mode 0, mask 2'b11, m_axis_tready[1]=0 for 3 cycles on beat 0xA5 -> master 0 takes 0xA5 once, master 1 takes it after release, s00_axis_tready low until then.
REQ-031 Mode 1, route_sel=1 on first beat, route_sel changed to 0 on beat 2 of 3 -> all 3 beats only on master 1.
REQ-032 Mode 1, route_sel=5 with NUM_MASTERS=2, 2-beat packet -> no m_axis_tvalid, slave accepts one beat per cycle, stat_drop_count=2 with AXIS_BCAST_STATS_EN.
REQ-033 Reset pulsed while beat 2 of 4 is buffered and master 0 stalled -> all m_axis_tvalid=0 immediately, next packet's first beat re-samples T.

Source files
------------

// File: rtl/axis_broadcaster.sv
// One-beat AXI-Stream broadcaster: each slave beat is replayed to a per-packet target set of masters.
// Optional statistics counters are enabled by defining AXIS_BCAST_STATS_EN.
module axis_broadcaster #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int NUM_MASTERS      = 2
) (
  input  logic                                      axis_aclk,
  input  logic                                      axis_areset,
  input  logic                                      mode,
  input  logic [NUM_MASTERS-1:0]                    enable_mask,
  input  logic [2:0]                                route_sel,
  input  logic                                      s00_axis_tvalid,
  output logic                                      s00_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]               s00_axis_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0]             s00_axis_tstrb,
  input  logic                                      s00_axis_tlast,
  output logic [NUM_MASTERS-1:0]                    m_axis_tvalid,
  input  logic [NUM_MASTERS-1:0]                    m_axis_tready,
  output logic [NUM_MASTERS-1:0]                    m_axis_tlast,
  output logic [NUM_MASTERS*AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_MASTERS*AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb
`ifdef AXIS_BCAST_STATS_EN
  ,
  output logic [31:0]                               stat_pkt_count,
  output logic [31:0]                               stat_drop_count
`endif
);

  localparam int STRB_W = AXIS_TDATA_WIDTH / 8;

  typedef enum logic {PKT_START, PKT_MID} pkt_state_t;

  pkt_state_t state, state_nxt;

  logic                        vld_p1;
  logic [AXIS_TDATA_WIDTH-1:0] data_p1;
  logic [STRB_W-1:0]           strb_p1;
  logic                        last_p1;
  logic [NUM_MASTERS-1:0]      tmask_p1;
  logic [NUM_MASTERS-1:0]      done_p1;
  logic [NUM_MASTERS-1:0]      pkt_mask;

  logic [NUM_MASTERS-1:0]      new_mask;
  logic [NUM_MASTERS-1:0]      beat_mask;
  logic [NUM_MASTERS-1:0]      hs;
  logic                        complete;
  logic                        accept;

  // Out-of-range indices give an empty target set, which makes the beat a discard.
  function automatic logic [NUM_MASTERS-1:0] onehot_sel(input logic [2:0] sel);
    logic [NUM_MASTERS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  assign new_mask  = mode ? onehot_sel(route_sel) : enable_mask;
  assign beat_mask = (state == PKT_START) ? new_mask : pkt_mask;

  assign m_axis_tvalid   = {NUM_MASTERS{vld_p1}} & tmask_p1 & ~done_p1;
  assign hs              = m_axis_tvalid & m_axis_tready;
  assign complete        = vld_p1 & (&(~tmask_p1 | done_p1 | hs));
  assign s00_axis_tready = ~axis_areset & (~vld_p1 | complete);
  assign accept          = s00_axis_tvalid & s00_axis_tready;

  assign m_axis_tdata = {NUM_MASTERS{data_p1}};
  assign m_axis_tstrb = {NUM_MASTERS{strb_p1}};
  assign m_axis_tlast = {NUM_MASTERS{last_p1}};

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = s00_axis_tlast ? PKT_START : PKT_MID;
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state    <= PKT_START;
      pkt_mask <= '0;
    end else begin
      state <= state_nxt;
      if (accept && state == PKT_START) pkt_mask <= new_mask;
    end
  end

  // Stage p1: single beat buffer, reloaded on the completing edge so there is no bubble.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      strb_p1  <= '0;
      last_p1  <= 1'b0;
      tmask_p1 <= '0;
      done_p1  <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      data_p1  <= s00_axis_tdata;
      strb_p1  <= s00_axis_tstrb;
      last_p1  <= s00_axis_tlast;
      tmask_p1 <= beat_mask;
      done_p1  <= '0;
    end else if (complete) begin
      vld_p1  <= 1'b0;
      done_p1 <= '0;
    end else begin
      done_p1 <= done_p1 | hs;
    end
  end

`ifdef AXIS_BCAST_STATS_EN
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      stat_pkt_count  <= '0;
      stat_drop_count <= '0;
    end else if (complete) begin
      if (~|tmask_p1)   stat_drop_count <= stat_drop_count + 32'd1;
      else if (last_p1) stat_pkt_count  <= stat_pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_broadcaster.sv
// Bench for axis_broadcaster (NUM_MASTERS=2, 32-bit): vector table, reset corner sequence and
// randomized traffic against a queue-based reference model.
module tb_axis_broadcaster;

  localparam int W = 32;
  localparam int N = 2;

  logic          axis_aclk = 1'b0;
  logic          axis_areset;
  logic          mode;
  logic [N-1:0]  enable_mask;
  logic [2:0]    route_sel;
  logic          s00_axis_tvalid;
  logic          s00_axis_tready;
  logic [W-1:0]  s00_axis_tdata;
  logic [W/8-1:0] s00_axis_tstrb;
  logic          s00_axis_tlast;
  logic [N-1:0]  m_axis_tvalid;
  logic [N-1:0]  m_axis_tready;
  logic [N-1:0]  m_axis_tlast;
  logic [N*W-1:0] m_axis_tdata;
  logic [N*W/8-1:0] m_axis_tstrb;
`ifdef AXIS_BCAST_STATS_EN
  logic [31:0]   stat_pkt_count;
  logic [31:0]   stat_drop_count;
`endif

  axis_broadcaster #(.AXIS_TDATA_WIDTH(W), .NUM_MASTERS(N)) dut (
    .axis_aclk       (axis_aclk),
    .axis_areset     (axis_areset),
    .mode            (mode),
    .enable_mask     (enable_mask),
    .route_sel       (route_sel),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tlast  (s00_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tstrb    (m_axis_tstrb)
`ifdef AXIS_BCAST_STATS_EN
    ,
    .stat_pkt_count  (stat_pkt_count),
    .stat_drop_count (stat_drop_count)
`endif
  );

  always #5 axis_aclk = ~axis_aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [W-1:0] d, input logic last, input logic md,
                       input logic [N-1:0] mk, input logic [2:0] rs, input logic [N-1:0] rdy);
    s00_axis_tvalid = sv;
    s00_axis_tdata  = d;
    s00_axis_tstrb  = 4'hF;
    s00_axis_tlast  = last;
    mode            = md;
    enable_mask     = mk;
    route_sel       = rs;
    m_axis_tready   = rdy;
  endtask

  task automatic do_reset();
    axis_areset = 1'b1;
    drive(0, '0, 0, 0, '0, '0, '0);
    repeat (2) @(posedge axis_aclk);
    @(negedge axis_aclk);
    check("reset_mvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset_sready", 64'(s00_axis_tready), 64'd0);
    axis_areset = 1'b0;
    #1;
    check("post_reset_sready", 64'(s00_axis_tready), 64'd1);
  endtask

  // Vector table: inputs for one cycle plus the outputs expected before the next edge.
  typedef struct {
    logic sv; logic [W-1:0] d; logic last; logic md; logic [N-1:0] mk; logic [2:0] rs;
    logic [N-1:0] rdy; logic exp_srdy; logic [N-1:0] exp_mvld; logic [W-1:0] exp_d; logic exp_last;
  } vec_t;

  vec_t tbl[22];

  // Reference model: per-master queues of expected {data, strb, last}.
  typedef logic [W+W/8:0] beat_t;
  beat_t q0[$];
  beat_t q1[$];
  logic       mdl_mid;
  logic [N-1:0] mdl_held;
  int exp_pkt, exp_drop;

  function automatic logic [N-1:0] spec_target(input logic md, input logic [N-1:0] mk,
                                               input logic [2:0] rs);
    if (!md) return mk;
    if (int'(rs) < N) return N'(1) << rs;
    return '0;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    mdl_mid  = 1'b0;
    mdl_held = '0;
    exp_pkt  = 0;
    exp_drop = 0;
  endtask

  task automatic model_step();
    beat_t got, b;
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      if (m_axis_tvalid[i]) begin
        got = {m_axis_tdata[i*W +: W], m_axis_tstrb[i*(W/8) +: W/8], m_axis_tlast[i]};
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          check($sformatf("rnd_unexpected_valid_m%0d", i), 64'd1, 64'd0);
        end else begin
          b = (i == 0) ? q0[0] : q1[0];
          check($sformatf("rnd_beat_m%0d", i), 64'(got), 64'(b));
          if (m_axis_tready[i]) begin
            if (i == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end
    end
    if (s00_axis_tvalid && s00_axis_tready) begin
      t = mdl_mid ? mdl_held : spec_target(mode, enable_mask, route_sel);
      mdl_held = t;
      mdl_mid  = !s00_axis_tlast;
      b = {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast};
      if (t[0]) q0.push_back(b);
      if (t[1]) q1.push_back(b);
      if (t == '0) exp_drop++;
      else if (s00_axis_tlast) exp_pkt++;
    end
  endtask

  initial begin
    //            sv d      l  md mk rs rdy  srdy mvld exp_d  el
    tbl[0]  = '{1, 32'h01, 0, 0, 3, 0, 3,   1,   0, 32'h00, 0};
    tbl[1]  = '{1, 32'h02, 0, 0, 3, 0, 3,   1,   3, 32'h01, 0};
    tbl[2]  = '{1, 32'h03, 0, 0, 3, 0, 3,   1,   3, 32'h02, 0};
    tbl[3]  = '{1, 32'h04, 1, 0, 3, 0, 3,   1,   3, 32'h03, 0};
    tbl[4]  = '{0, 32'h00, 0, 0, 3, 0, 3,   1,   3, 32'h04, 1};
    tbl[5]  = '{0, 32'h00, 0, 0, 3, 0, 3,   1,   0, 32'h00, 0};
    tbl[6]  = '{1, 32'hA5, 1, 0, 3, 0, 1,   1,   0, 32'h00, 0};
    tbl[7]  = '{1, 32'hB6, 1, 0, 3, 0, 1,   0,   3, 32'hA5, 1};
    tbl[8]  = '{1, 32'hB6, 1, 0, 3, 0, 1,   0,   2, 32'hA5, 1};
    tbl[9]  = '{1, 32'hB6, 1, 0, 3, 0, 1,   0,   2, 32'hA5, 1};
    tbl[10] = '{1, 32'hB6, 1, 0, 3, 0, 3,   1,   2, 32'hA5, 1};
    tbl[11] = '{0, 32'h00, 0, 0, 3, 0, 3,   1,   3, 32'hB6, 1};
    tbl[12] = '{0, 32'h00, 0, 0, 3, 0, 3,   1,   0, 32'h00, 0};
    tbl[13] = '{1, 32'h10, 0, 1, 3, 1, 3,   1,   0, 32'h00, 0};
    tbl[14] = '{1, 32'h11, 0, 1, 3, 0, 3,   1,   2, 32'h10, 0};
    tbl[15] = '{1, 32'h12, 1, 1, 3, 0, 3,   1,   2, 32'h11, 0};
    tbl[16] = '{0, 32'h00, 0, 1, 3, 0, 3,   1,   2, 32'h12, 1};
    tbl[17] = '{0, 32'h00, 0, 1, 3, 0, 3,   1,   0, 32'h00, 0};
    tbl[18] = '{1, 32'h20, 0, 1, 3, 5, 3,   1,   0, 32'h00, 0};
    tbl[19] = '{1, 32'h21, 1, 1, 3, 5, 3,   1,   0, 32'h00, 0};
    tbl[20] = '{0, 32'h00, 0, 1, 3, 5, 3,   1,   0, 32'h00, 0};
    tbl[21] = '{0, 32'h00, 0, 1, 3, 5, 3,   1,   0, 32'h00, 0};

    do_reset();

    for (int v = 0; v < 22; v++) begin
      @(posedge axis_aclk);
      #1;
      drive(tbl[v].sv, tbl[v].d, tbl[v].last, tbl[v].md, tbl[v].mk, tbl[v].rs, tbl[v].rdy);
      @(negedge axis_aclk);
      check($sformatf("vec%0d_sready", v), 64'(s00_axis_tready), 64'(tbl[v].exp_srdy));
      check($sformatf("vec%0d_mvalid", v), 64'(m_axis_tvalid), 64'(tbl[v].exp_mvld));
      for (int i = 0; i < N; i++) begin
        if (tbl[v].exp_mvld[i]) begin
          check($sformatf("vec%0d_data_m%0d", v, i), 64'(m_axis_tdata[i*W +: W]), 64'(tbl[v].exp_d));
          check($sformatf("vec%0d_last_m%0d", v, i), 64'(m_axis_tlast[i]), 64'(tbl[v].exp_last));
        end
      end
    end
`ifdef AXIS_BCAST_STATS_EN
    check("vec_stat_pkt", 64'(stat_pkt_count), 64'd4);
    check("vec_stat_drop", 64'(stat_drop_count), 64'd2);
`endif

    // Reset while beat 2 of 4 is buffered and master 0 is stalled.
    @(posedge axis_aclk); #1; drive(1, 32'h31, 0, 0, 3, 0, 3);
    @(posedge axis_aclk); #1; drive(1, 32'h32, 0, 0, 3, 0, 3);
    @(posedge axis_aclk); #1; drive(1, 32'h33, 0, 0, 3, 0, 2'b10);
    @(negedge axis_aclk);
    check("rst_seq_mvalid_a", 64'(m_axis_tvalid), 64'd3);
    check("rst_seq_data_a", 64'(m_axis_tdata[W-1:0]), 64'h32);
    check("rst_seq_sready_a", 64'(s00_axis_tready), 64'd0);
    @(posedge axis_aclk); #1;
    @(negedge axis_aclk);
    check("rst_seq_mvalid_b", 64'(m_axis_tvalid), 64'd1);
    #1 axis_areset = 1'b1;
    #1;
    check("rst_seq_mvalid_now", 64'(m_axis_tvalid), 64'd0);
    check("rst_seq_sready_now", 64'(s00_axis_tready), 64'd0);
    @(posedge axis_aclk); #1;
    axis_areset = 1'b0;
    drive(1, 32'h40, 1, 1, 3, 0, 3);
    @(negedge axis_aclk);
    check("rst_seq_sready_after", 64'(s00_axis_tready), 64'd1);
    check("rst_seq_mvalid_after", 64'(m_axis_tvalid), 64'd0);
    @(posedge axis_aclk); #1; drive(0, '0, 0, 0, 3, 0, 3);
    @(negedge axis_aclk);
    check("rst_seq_resampled_T", 64'(m_axis_tvalid), 64'd1);
    check("rst_seq_data", 64'(m_axis_tdata[W-1:0]), 64'h40);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge axis_aclk); #1;
      s00_axis_tvalid = ($urandom % 4) != 0;
      s00_axis_tdata  = $urandom;
      s00_axis_tstrb  = 4'($urandom);
      s00_axis_tlast  = ($urandom % 4) == 0;
      mode            = 1'($urandom);
      enable_mask     = 2'($urandom);
      route_sel       = 3'($urandom_range(0, 2));
      if (($urandom % 16) == 0) route_sel = 3'($urandom_range(3, 7));
      m_axis_tready   = 2'($urandom);
      @(negedge axis_aclk);
      model_step();
    end
    @(posedge axis_aclk); #1;
    s00_axis_tvalid = 1'b0;
    m_axis_tready   = '1;
    for (int c = 0; c < 10 && (q0.size() != 0 || q1.size() != 0 || m_axis_tvalid != '0); c++) begin
      @(negedge axis_aclk);
      model_step();
      @(posedge axis_aclk); #1;
    end
    @(negedge axis_aclk);
    check("rnd_drain_q0", 64'(q0.size()), 64'd0);
    check("rnd_drain_q1", 64'(q1.size()), 64'd0);
    check("rnd_drain_mvalid", 64'(m_axis_tvalid), 64'd0);
`ifdef AXIS_BCAST_STATS_EN
    check("rnd_stat_pkt", 64'(stat_pkt_count), 64'(exp_pkt));
    check("rnd_stat_drop", 64'(stat_drop_count), 64'(exp_drop));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
